// File: rtl/des_mode_engine.sv
// ECB/CBC/CTR mode sequencer in front of a single DES core, with an input FIFO and one block in flight.
// A block pushed at edge t is popped at t+1 and issued at t+2; s_ready drops when the FIFO is full, m_valid holds until m_ready.
module des_mode_engine #(
    parameter int DEPTH   = 4,
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cfg_load,
    input  logic [1:0]               cfg_mode,
    input  logic                     cfg_encrypt_decrypt,
    input  logic [KEY_W-1:0]         cfg_key,
    input  logic [BLOCK_W-1:0]       cfg_iv,
    input  logic                     s_valid,
    input  logic [BLOCK_W-1:0]       s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [BLOCK_W-1:0]       m_data,
    input  logic                     m_ready,
    output logic [BLOCK_W-1:0]       core_plain_text,
    output logic [KEY_W-1:0]         core_cipher_key,
    output logic                     core_encrypt_decrypt,
    output logic                     core_valid_in,
    input  logic [BLOCK_W-1:0]       core_cipher_text,
    input  logic                     core_valid_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLOCK_W-1:0] chain_q, chain_d, hold_q, hold_d, m_data_q, m_data_d, core_in;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d, m_valid_q, m_valid_d;
    logic               push, pop, is_cbc, is_ctr;

    // Reserved mode 11 falls through to ECB behaviour everywhere.
    assign is_cbc = (mode_q == 2'b01);
    assign is_ctr = (mode_q == 2'b10);

    assign s_ready              = (count_q < FULL);
    assign push                 = s_valid && s_ready;
    assign busy                 = (count_q != '0) || (state_q != IDLE) || m_valid_q;
    assign fifo_count           = count_q;
    assign m_valid              = m_valid_q;
    assign m_data               = m_data_q;
    assign core_cipher_key      = key_q;
    assign core_encrypt_decrypt = is_ctr ? 1'b1 : dir_q;
    assign core_valid_in        = (state_q == ISSUE);
    assign core_plain_text      = core_in;

    always_comb begin
        core_in = hold_q;
        if (is_ctr) begin
            core_in = chain_q;
        end else if (is_cbc && dir_q) begin
            core_in = hold_q ^ chain_q;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        chain_d   = chain_q;
        key_d     = key_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        pop       = 1'b0;

        if (cfg_load && !busy) begin
            key_d   = cfg_key;
            chain_d = cfg_iv;
            mode_d  = cfg_mode;
            dir_d   = cfg_encrypt_decrypt;
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (core_valid_out) begin
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                    if (is_ctr) begin
                        m_data_d = core_cipher_text ^ hold_q;
                        chain_d  = chain_q + BLOCK_W'(1);
                    end else if (is_cbc && dir_q) begin
                        m_data_d = core_cipher_text;
                        chain_d  = core_cipher_text;
                    end else if (is_cbc) begin
                        m_data_d = core_cipher_text ^ chain_q;
                        chain_d  = hold_q;
                    end else begin
                        m_data_d = core_cipher_text;
                    end
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            key_q     <= '0;
            chain_q   <= '0;
            hold_q    <= '0;
            mode_q    <= 2'b00;
            dir_q     <= 1'b1;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            key_q     <= key_d;
            chain_q   <= chain_d;
            hold_q    <= hold_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end
endmodule
